spi_slave_peripheral: RTL and testbench

Memory-mapped SPI slave (target) peripheral: the responder end of the SPI link, for use when an external master drives SCK/CS. It samples SCK, CS_N and MOSI into the system clock domain, shifts received bytes into an RX register, and shifts out a CPU-written TX byte on MISO. It uses the same 8-bit word-address MMIO bus as the SoC's other peripherals and raises an optional interrupt on byte reception.

---
 rtl/spi_slave_peripheral.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_peripheral.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_peripheral.sv
// SPI target (slave) with an MMIO register file: CONTROL, TX_DATA, RX_DATA, STATUS.
// Latency: a pin edge takes effect 3 clk later and MISO follows 1 clk after the detected shift edge.
// Backpressure: none on SPI; TX underrun and RX overrun are reported through sticky STATUS flags.
module spi_slave_peripheral #(
   parameter bit         CPOL       = 1'b0,
   parameter bit         CPHA       = 1'b0,
   parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sck,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [7:0]  mem_addr,
   input  logic [3:0]  mem_wr_en,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_rd_en,
   output logic [31:0] mem_rd_data,
   output logic        irq
);

   typedef enum logic [1:0] {
      ST_DISABLED,
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   // [0],[1] form the synchroniser, [2] is the history flop for edge detection
   logic [2:0] sck_sync;
   logic [2:0] cs_sync;
   logic [1:0] mosi_sync;

   state_t     state;
   logic       frame_active;
   logic       enable;
   logic       irq_en;
   logic [7:0] tx_hold;
   logic       tx_full;
   logic [7:0] tx_shift;
   logic [7:0] rx_shift;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_overrun;
   logic       frame_abort;
   logic       tx_underrun;
   logic [2:0] bit_cnt;

   logic       sck_edge;
   logic       lead_edge;
   logic       trail_edge;
   logic       cs_fall;
   logic       cs_rise;
   logic       in_frame;
   logic       sample_evt;
   logic       shift_evt;
   logic       frame_start;
   logic       load_evt;
   logic       byte_done;
   logic [7:0] rx_byte;
   logic       wr_ctl;
   logic       wr_tx;
   logic       pop;
   logic       clear_flags;
   logic       unused_bits;

   assign unused_bits = ^{mem_wr_en[3:1], mem_wr_data[31:8]};

   // Bring the asynchronous SPI pins into the clk domain
   always_ff @(posedge clk) begin
      if (!rst) begin
         sck_sync  <= {3{CPOL}};
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sck_sync  <= {sck_sync[1:0], spi_sck};
         cs_sync   <= {cs_sync[1:0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
      end
   end

   // Decode pin edges and bus accesses into single-cycle events
   always_comb begin
      sck_edge    = sck_sync[1] ^ sck_sync[2];
      lead_edge   = sck_edge & (sck_sync[2] == CPOL);
      trail_edge  = sck_edge & (sck_sync[2] != CPOL);
      cs_fall     = cs_sync[2] & ~cs_sync[1];
      cs_rise     = ~cs_sync[2] & cs_sync[1];
      // a CS rise ends the frame even if an SCK edge lands in the same cycle
      in_frame    = (state == ST_ACTIVE) & enable & ~cs_rise;
      sample_evt  = in_frame & (CPHA ? trail_edge : lead_edge);
      shift_evt   = in_frame & (CPHA ? lead_edge : trail_edge);
      frame_start = (state == ST_IDLE) & enable & cs_fall;
      // bit_cnt==0 on a shift edge means either the first leading edge (CPHA=1)
      // or the trailing edge right after a completed byte (CPHA=0)
      load_evt    = (frame_start & ~CPHA) | (shift_evt & (bit_cnt == 3'd0));
      byte_done   = sample_evt & (bit_cnt == 3'd7);
      rx_byte     = {rx_shift[6:0], mosi_sync[1]};
      wr_ctl      = mem_wr_en[0] & (mem_addr == 8'h00);
      wr_tx       = mem_wr_en[0] & (mem_addr == 8'h01);
      pop         = mem_rd_en & (mem_addr == 8'h02);
      clear_flags = wr_ctl & mem_wr_data[2];
   end

   // Frame FSM, shifters and register file; later assignments win so flag sets beat clears
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_DISABLED;
         frame_active <= 1'b0;
         enable       <= 1'b0;
         irq_en       <= 1'b0;
         tx_hold      <= 8'h00;
         tx_full      <= 1'b0;
         tx_shift     <= 8'h00;
         rx_shift     <= 8'h00;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         frame_abort  <= 1'b0;
         tx_underrun  <= 1'b0;
         bit_cnt      <= 3'd0;
      end else begin
         if (wr_ctl) begin
            enable <= mem_wr_data[0];
            irq_en <= mem_wr_data[1];
         end
         if (clear_flags) begin
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
            tx_underrun <= 1'b0;
         end
         if (pop) begin
            rx_valid <= 1'b0;
         end

         // the load sees tx_hold/tx_full as they were before any same-cycle write
         if (load_evt) begin
            if (tx_full) begin
               tx_shift <= tx_hold;
               tx_full  <= 1'b0;
            end else begin
               tx_shift    <= DEFAULT_TX;
               tx_underrun <= 1'b1;
            end
         end else if (shift_evt) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
         end
         if (wr_tx) begin
            tx_hold <= mem_wr_data[7:0];
            tx_full <= 1'b1;
         end

         if (sample_evt) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
         end
         if (byte_done) begin
            rx_data  <= rx_byte;
            rx_valid <= 1'b1;
            if (rx_valid && !pop) begin
               rx_overrun <= 1'b1;
            end
         end

         case (state)
            ST_DISABLED: begin
               // never join a frame already in progress
               if (enable && cs_sync[1]) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (frame_start) begin
                  state        <= ST_ACTIVE;
                  frame_active <= 1'b1;
                  bit_cnt      <= 3'd0;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state        <= ST_IDLE;
                  frame_active <= 1'b0;
                  bit_cnt      <= 3'd0;
                  if (bit_cnt != 3'd0) begin
                     frame_abort <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_DISABLED;
            end
         endcase

         // disabling aborts silently from any state
         if (!enable) begin
            state        <= ST_DISABLED;
            frame_active <= 1'b0;
            bit_cnt      <= 3'd0;
         end
      end
   end

   // Read mux; forced to zero while reset is asserted
   always_comb begin
      mem_rd_data = 32'h0;
      if (rst) begin
         case (mem_addr)
            8'h00:   mem_rd_data = {30'h0, irq_en, enable};
            8'h02:   mem_rd_data = {24'h0, rx_data};
            8'h03:   mem_rd_data = {26'h0, tx_underrun, frame_abort, rx_overrun,
                                    frame_active, tx_full, rx_valid};
            default: mem_rd_data = 32'h0;
         endcase
      end
   end

   assign spi_miso    = tx_shift[7];
   assign spi_miso_oe = frame_active;
   assign irq         = rx_valid & irq_en;

endmodule

// File: tb/tb_spi_slave_peripheral.sv
// Bench for spi_slave_peripheral: a mode-0 and a mode-3 instance driven by a bit-banged master.
// Latency: SCK runs at clk/16; all stimulus changes on the falling clk edge.
// Backpressure: none; expected data comes from a frame-level model of the TX/RX registers.
module tb_spi_slave_peripheral;

   localparam int H = 8;

   logic        clk;
   logic        rst;
   logic [1:0]  sck;
   logic [1:0]  cs_n;
   logic [1:0]  mosi;
   logic [1:0]  rd_en;
   logic [1:0]  wr_b;
   logic [7:0]  addr;
   logic [31:0] wdata;
   wire  [1:0]  miso;
   wire  [1:0]  oe;
   wire  [1:0]  irq;
   wire  [31:0] rd0;
   wire  [31:0] rd1;

   int total;
   int bad;

   // frame-level model of each instance's register state
   bit         m_full  [2];
   bit         m_valid [2];
   bit         m_ovr   [2];
   bit         m_und   [2];
   logic [7:0] m_hold  [2];
   logic [7:0] m_rx    [2];

   typedef struct {
      int         md;
      logic [2:0] ctl;
      bit         wr;
      logic [7:0] tx;
      logic [7:0] mo;
      logic [7:0] mi;
      bit         last;
      logic [7:0] rx;
      logic [7:0] st;
      bit         irq;
      bit         pop;
   } vec_t;

   spi_slave_peripheral #(.CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) dut0 (
      .clk(clk), .rst(rst),
      .spi_sck(sck[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]),
      .spi_miso(miso[0]), .spi_miso_oe(oe[0]),
      .mem_addr(addr), .mem_wr_en({3'b000, wr_b[0]}), .mem_wr_data(wdata),
      .mem_rd_en(rd_en[0]), .mem_rd_data(rd0), .irq(irq[0])
   );

   spi_slave_peripheral #(.CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'hFF)) dut1 (
      .clk(clk), .rst(rst),
      .spi_sck(sck[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]),
      .spi_miso(miso[1]), .spi_miso_oe(oe[1]),
      .mem_addr(addr), .mem_wr_en({3'b000, wr_b[1]}), .mem_wr_data(wdata),
      .mem_rd_en(rd_en[1]), .mem_rd_data(rd1), .irq(irq[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal;
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic wr(input int md, input logic [7:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      wr_b[md] = 1'b1;
      wclk(1);
      wr_b[md] = 1'b0;
   endtask

   task automatic rd(input int md, input logic [7:0] a, input bit p, output logic [31:0] d);
      addr = a;
      rd_en[md] = p;
      #1;
      d = (md == 1) ? rd1 : rd0;
      wclk(1);
      rd_en[md] = 1'b0;
   endtask

   // holds an RX_DATA pop high across the clk edge where a sample edge driven 3 cycles ago acts
   task automatic after_sample(input int md, input bit p);
      if (p) begin
         wclk(2);
         addr = 8'h02;
         rd_en[md] = 1'b1;
         wclk(1);
         rd_en[md] = 1'b0;
      end else begin
         wclk(3);
      end
   endtask

   task automatic xfer(input int md, input logic [7:0] mo, input bit pop_last,
                       output logic [7:0] mi);
      bit cpol;
      bit cpha;
      cpol = (md == 1);
      cpha = (md == 1);
      for (int b = 7; b >= 0; b--) begin
         if (!cpha) begin
            mosi[md] = mo[b];
            wclk(H);
            sck[md] = ~cpol;
            mi[b] = miso[md];
            after_sample(md, pop_last && (b == 0));
            wclk(H - 3);
            sck[md] = cpol;
         end else begin
            sck[md] = ~cpol;
            mosi[md] = mo[b];
            wclk(H);
            sck[md] = cpol;
            mi[b] = miso[md];
            after_sample(md, pop_last && (b == 0));
            wclk(H - 3);
         end
      end
      wclk(6);
   endtask

   function automatic logic [7:0] mload(input int md);
      if (m_full[md]) begin
         m_full[md] = 1'b0;
         return m_hold[md];
      end
      m_und[md] = 1'b1;
      return 8'hFF;
   endfunction

   initial begin
      vec_t        vecs [7];
      vec_t        v;
      logic [31:0] d;
      logic [7:0]  mi;
      logic [7:0]  mo;
      logic [7:0]  t;
      logic [7:0]  ex;
      logic [7:0]  nxt;
      int          md;
      int          n;

      //           md ctl  wr tx     mo     mi     last rx     st     irq pop
      vecs[0] = '{0, 3'd3, 1, 8'hA5, 8'h3C, 8'hA5, 1, 8'h3C, 8'h21, 1, 1};
      vecs[1] = '{0, 3'd7, 1, 8'hA5, 8'h11, 8'hA5, 0, 8'h11, 8'h25, 1, 0};
      vecs[2] = '{0, 3'd3, 0, 8'h00, 8'h22, 8'hFF, 1, 8'h22, 8'h29, 1, 1};
      vecs[3] = '{1, 3'd1, 1, 8'h5A, 8'hC3, 8'h5A, 1, 8'hC3, 8'h01, 0, 1};
      vecs[4] = '{1, 3'd3, 1, 8'h96, 8'h0F, 8'h96, 0, 8'h0F, 8'h05, 1, 0};
      vecs[5] = '{1, 3'd3, 0, 8'h00, 8'hF0, 8'hFF, 1, 8'hF0, 8'h29, 1, 1};
      vecs[6] = '{0, 3'd7, 1, 8'hC3, 8'h5A, 8'hC3, 1, 8'h5A, 8'h21, 1, 1};

      total = 0;
      bad = 0;
      rst = 1'b0;
      sck = 2'b10;
      cs_n = 2'b11;
      mosi = 2'b00;
      rd_en = 2'b00;
      wr_b = 2'b00;
      addr = 8'h03;
      wdata = 32'h0;

      // reset state
      wclk(4);
      check("rst_miso", {30'h0, miso}, 32'h0);
      check("rst_oe", {30'h0, oe}, 32'h0);
      check("rst_irq", {30'h0, irq}, 32'h0);
      check("rst_rdata", rd0, 32'h0);
      rst = 1'b1;
      wclk(2);
      for (int a = 0; a < 4; a++) begin
         rd(0, 8'(a), 0, d);
         check($sformatf("reset_reg%0d", a), d, 32'h0);
      end
      rd(1, 8'h03, 0, d);
      check("reset_status_m3", d, 32'h0);

      // directed single- and multi-byte frames in both modes
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         wr(v.md, 8'h00, {29'h0, v.ctl});
         if (v.wr) wr(v.md, 8'h01, {24'h0, v.tx});
         wclk(2);
         if (cs_n[v.md]) begin
            cs_n[v.md] = 1'b0;
            wclk(H);
         end
         xfer(v.md, v.mo, 1'b0, mi);
         check($sformatf("vec%0d_miso", i), {24'h0, mi}, {24'h0, v.mi});
         if (v.last) begin
            cs_n[v.md] = 1'b1;
            wclk(8);
         end
         rd(v.md, 8'h03, 0, d);
         check($sformatf("vec%0d_status", i), d, {24'h0, v.st});
         check($sformatf("vec%0d_irq", i), {31'h0, irq[v.md]}, {31'h0, v.irq});
         rd(v.md, 8'h02, v.pop, d);
         check($sformatf("vec%0d_rx", i), d, {24'h0, v.rx});
      end

      // CS released after 5 SCK edges: partial byte dropped, frame_abort set
      wr(0, 8'h00, 32'h7);
      wr(0, 8'h01, 32'h7E);
      cs_n[0] = 1'b0;
      for (int e = 0; e < 5; e++) begin
         mosi[0] = e[0];
         wclk(H);
         sck[0] = ~sck[0];
      end
      wclk(H);
      cs_n[0] = 1'b1;
      wclk(8);
      sck[0] = 1'b0;
      wclk(8);
      rd(0, 8'h03, 0, d);
      check("abort_status", d, 32'h10);
      rd(0, 8'h02, 0, d);
      check("abort_rx_kept", d, 32'h5A);
      cs_n[0] = 1'b0;
      wclk(H);
      xfer(0, 8'h81, 1'b0, mi);
      check("after_abort_miso", {24'h0, mi}, 32'hFF);
      cs_n[0] = 1'b1;
      wclk(8);
      rd(0, 8'h02, 0, d);
      check("after_abort_rx", d, 32'h81);
      rd(0, 8'h03, 0, d);
      check("after_abort_status", d, 32'h31);

      // pop in the very cycle the next byte completes: no overrun
      wr(0, 8'h00, 32'h7);
      cs_n[0] = 1'b0;
      wclk(H);
      xfer(0, 8'h42, 1'b1, mi);
      cs_n[0] = 1'b1;
      wclk(8);
      rd(0, 8'h03, 0, d);
      check("pop_race_status", d, 32'h21);
      check("pop_race_no_overrun", {31'h0, d[3]}, 32'h0);
      rd(0, 8'h02, 1, d);
      check("pop_race_rx", d, 32'h42);

      // enable while CS is low: ignore the rest of that frame
      wr(0, 8'h00, 32'h0);
      wclk(4);
      cs_n[0] = 1'b0;
      wclk(H);
      for (int e = 0; e < 6; e++) begin
         mosi[0] = 1'b1;
         wclk(H);
         sck[0] = ~sck[0];
      end
      wr(0, 8'h00, 32'h3);
      wclk(4);
      check("midframe_oe", {31'h0, oe[0]}, 32'h0);
      xfer(0, 8'hE7, 1'b0, mi);
      check("midframe_oe_end", {31'h0, oe[0]}, 32'h0);
      rd(0, 8'h03, 0, d);
      check("midframe_status", d, 32'h20);
      rd(0, 8'h02, 0, d);
      check("midframe_rx", d, 32'h42);
      cs_n[0] = 1'b1;
      wclk(8);
      cs_n[0] = 1'b0;
      wclk(H);
      check("newframe_oe", {31'h0, oe[0]}, 32'h1);
      xfer(0, 8'h99, 1'b0, mi);
      check("newframe_miso", {24'h0, mi}, 32'hFF);
      rd(0, 8'h02, 0, d);
      check("newframe_rx", d, 32'h99);
      check("newframe_irq", {31'h0, irq[0]}, 32'h1);
      for (int e = 0; e < 4; e++) begin
         mosi[0] = 1'b0;
         wclk(H);
         sck[0] = ~sck[0];
      end
      wclk(5);
      check("premreset_miso", {31'h0, miso[0]}, 32'h1);

      // synchronous reset mid-byte
      addr = 8'h03;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_miso", {31'h0, miso[0]}, 32'h0);
      check("midrst_oe", {31'h0, oe[0]}, 32'h0);
      check("midrst_irq", {31'h0, irq[0]}, 32'h0);
      check("midrst_rdata", rd0, 32'h0);
      wclk(1);
      cs_n[0] = 1'b1;
      sck[0] = 1'b0;
      wclk(3);
      rst = 1'b1;
      wclk(2);

      // randomized frames against the frame-level model
      for (int k = 0; k < 2; k++) begin
         m_full[k] = 0;
         m_valid[k] = 0;
         m_ovr[k] = 0;
         m_und[k] = 0;
         m_hold[k] = 8'h00;
         m_rx[k] = 8'h00;
         wr(k, 8'h00, 32'h1);
      end
      wclk(4);
      for (int it = 0; it < 24; it++) begin
         md = int'($urandom_range(1, 0));
         n = int'($urandom_range(3, 1));
         if ($urandom_range(1, 0) == 1) begin
            t = 8'($urandom);
            wr(md, 8'h01, {24'h0, t});
            m_hold[md] = t;
            m_full[md] = 1'b1;
         end
         if ($urandom_range(3, 0) == 0) begin
            wr(md, 8'h00, 32'h5);
            m_ovr[md] = 1'b0;
            m_und[md] = 1'b0;
         end
         if ($urandom_range(2, 0) == 0) begin
            rd(md, 8'h02, 1, d);
            check("rnd_pop_rx", d, {24'h0, m_rx[md]});
            m_valid[md] = 1'b0;
         end
         wclk(2);
         cs_n[md] = 1'b0;
         wclk(H);
         nxt = 8'h00;
         if (md == 0) nxt = mload(0);
         for (int b = 0; b < n; b++) begin
            mo = 8'($urandom);
            if (md == 0) ex = nxt;
            else ex = mload(1);
            xfer(md, mo, 1'b0, mi);
            check($sformatf("rnd%0d_miso", it), {24'h0, mi}, {24'h0, ex});
            if (m_valid[md]) m_ovr[md] = 1'b1;
            m_rx[md] = mo;
            m_valid[md] = 1'b1;
            if (md == 0) nxt = mload(0);
         end
         cs_n[md] = 1'b1;
         wclk(8);
         rd(md, 8'h03, 0, d);
         check($sformatf("rnd%0d_status", it), d,
               {26'h0, m_und[md], 1'b0, m_ovr[md], 1'b0, m_full[md], m_valid[md]});
         rd(md, 8'h02, 0, d);
         check($sformatf("rnd%0d_rx", it), d, {24'h0, m_rx[md]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
